// File: rtl/ldm_stm_seq_if.sv
// Data-memory beat port of the LDM/STM sequencer: one request/acknowledge word transfer per beat.
interface ldm_stm_seq_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register list lowest-first, one memory beat per
// register, then optionally writes the final address back to the base register.
module ldm_stm_seq #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  pre,
    input  logic                  up,
    input  logic                  wback,
    input  logic [3:0]            base_reg,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           reg_list,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            rf_reg_num,
    output logic                  rf_write_en,
    output logic [31:0]           rf_data_in,
    input  logic [31:0]           rf_data_out,
    output logic                  pc_write_en,
    output logic [31:0]           pc_in,
    ldm_stm_seq_if.master         bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StXfer = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [3:0] PcReg = 4'd15;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        popcount16 = '0;
        for (int i = 0; i < 16; i++) begin
            popcount16 = popcount16 + 5'(v[i]);
        end
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [15:0] v);
        lowest_bit = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_bit = 4'(i);
        end
    endfunction

    logic [1:0]        state_q, state_d;
    logic [15:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_val_q, wb_val_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic              is_load_q, is_load_d;
    logic              do_wb_q, do_wb_d;

    logic [4:0]        reg_count;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] step;
    logic [3:0]        cur_reg;
    logic              beat;

    assign reg_count = popcount16(reg_list);
    assign step      = ADDR_W'(WORD_BYTES);
    assign span      = ADDR_W'(reg_count) * step;
    assign cur_reg   = lowest_bit(remain_q);
    // mem_req is high throughout StXfer, so an ack there always completes the beat.
    assign beat      = (state_q == StXfer) && bus.mem_ack;

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        wb_val_d   = wb_val_q;
        base_reg_d = base_reg_q;
        is_load_d  = is_load_q;
        do_wb_d    = do_wb_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    remain_d   = reg_list;
                    base_reg_d = base_reg;
                    is_load_d  = is_load;
                    // A loaded base register keeps the loaded value, not the writeback.
                    do_wb_d    = wback && !(is_load && reg_list[base_reg]);
                    wb_val_d   = up ? (base_addr + span) : (base_addr - span);
                    case ({up, pre})
                        2'b10:   addr_d = base_addr;
                        2'b11:   addr_d = base_addr + step;
                        2'b00:   addr_d = base_addr - span + step;
                        default: addr_d = base_addr - span;
                    endcase
                    state_d = (reg_count == 5'd0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                if (beat) begin
                    remain_d = remain_q & ~(16'd1 << cur_reg);
                    addr_d   = addr_q + step;
                    if (remain_d == 16'd0) begin
                        state_d = do_wb_q ? StWb : StDone;
                    end
                end
            end
            StWb: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            remain_q   <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            base_reg_q <= '0;
            is_load_q  <= 1'b0;
            do_wb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            wb_val_q   <= wb_val_d;
            base_reg_q <= base_reg_d;
            is_load_q  <= is_load_d;
            do_wb_q    <= do_wb_d;
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rf_reg_num    = '0;
        rf_write_en   = 1'b0;
        rf_data_in    = '0;
        pc_write_en   = 1'b0;
        pc_in         = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state_q)
            StXfer: begin
                busy          = 1'b1;
                rf_reg_num    = cur_reg;
                bus.mem_req   = 1'b1;
                bus.mem_we    = !is_load_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = is_load_q ? 32'd0 : rf_data_out;
                if (is_load_q && bus.mem_ack) begin
                    // R15 is the PC and is written through the PC path, never the file.
                    if (cur_reg == PcReg) begin
                        pc_write_en = 1'b1;
                        pc_in       = bus.mem_rdata;
                    end else begin
                        rf_write_en = 1'b1;
                        rf_data_in  = bus.mem_rdata;
                    end
                end
            end
            StWb: begin
                busy        = 1'b1;
                rf_write_en = 1'b1;
                rf_reg_num  = base_reg_q;
                rf_data_in  = 32'(wb_val_q);
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    a_wr_excl: assert property (@(posedge clk) disable iff (!reset)
        !(rf_write_en && pc_write_en));

    a_xfer_nonempty: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StXfer) |-> (remain_q != 16'd0));

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: memory responder with wait states, register-file model and
// beat/write logs compared against hand-computed expectations.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        pre = 1'b0;
    logic        up = 1'b0;
    logic        wback = 1'b0;
    logic [3:0]  base_reg = '0;
    logic [31:0] base_addr = '0;
    logic [15:0] reg_list = '0;
    logic        busy;
    logic        done;
    logic [3:0]  rf_reg_num;
    logic        rf_write_en;
    logic [31:0] rf_data_in;
    logic [31:0] rf_data_out;
    logic        pc_write_en;
    logic [31:0] pc_in;

    ldm_stm_seq_if #(.ADDR_W(32)) bus ();

    ldm_stm_seq #(
        .ADDR_W     (32),
        .WORD_BYTES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_load     (is_load),
        .pre         (pre),
        .up          (up),
        .wback       (wback),
        .base_reg    (base_reg),
        .base_addr   (base_addr),
        .reg_list    (reg_list),
        .busy        (busy),
        .done        (done),
        .rf_reg_num  (rf_reg_num),
        .rf_write_en (rf_write_en),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .pc_write_en (pc_write_en),
        .pc_in       (pc_in),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [16];
    assign rf_data_out = regs[rf_reg_num];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_edge = 0;
    int done_cnt = 0;
    int done_base = 0;
    int excl_cnt = 0;
    int req_cnt = 0;
    int req_base = 0;
    int beat_idx = 0;
    int beat_base = 0;
    int wait_states = 0;
    int lat = 0;

    logic [31:0] load_data [8];
    logic [31:0] beat_addr [$];
    logic [31:0] beat_data [$];
    logic        beat_we [$];
    logic [3:0]  rfw_num [$];
    logic [31:0] rfw_data [$];
    logic [31:0] pcw_data [$];

    // Register file plus event logs, all sampled on the active edge.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'hA000_0000 + 32'(i);
        end else if (rf_write_en) begin
            regs[rf_reg_num] <= rf_data_in;
        end
        if (rf_write_en) begin
            rfw_num.push_back(rf_reg_num);
            rfw_data.push_back(rf_data_in);
        end
        if (pc_write_en) pcw_data.push_back(pc_in);
        if (bus.mem_req && bus.mem_ack) begin
            beat_addr.push_back(bus.mem_addr);
            beat_data.push_back(bus.mem_wdata);
            beat_we.push_back(bus.mem_we);
            beat_idx <= beat_idx + 1;
        end
        if (bus.mem_req) req_cnt <= req_cnt + 1;
        if (rf_write_en && pc_write_en) excl_cnt <= excl_cnt + 1;
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc;
        end
        cyc <= cyc + 1;
    end

    // Memory responder: acks after wait_states idle request cycles.
    initial begin
        int wcnt;
        logic [2:0] li;
        wcnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req && wcnt == wait_states) begin
                li = 3'(beat_idx - beat_base);
                bus.mem_ack = 1'b1;
                bus.mem_rdata = load_data[li];
                wcnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = '0;
                if (bus.mem_req) wcnt++;
                else wcnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic ld, input logic p, input logic u, input logic w,
                              input logic [3:0] br, input logic [31:0] ba,
                              input logic [15:0] rl, input int ws);
        @(posedge clk);
        #1;
        beat_addr.delete();
        beat_data.delete();
        beat_we.delete();
        rfw_num.delete();
        rfw_data.delete();
        pcw_data.delete();
        beat_base   = beat_idx;
        done_base   = done_cnt;
        req_base    = req_cnt;
        wait_states = ws;
        is_load = ld; pre = p; up = u; wback = w;
        base_reg = br; base_addr = ba; reg_list = rl;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        start = 1'b0;
        // Scramble the request fields: the sequencer must work from its latched copy.
        is_load = ~ld; pre = ~p; up = ~u; wback = ~w;
        base_reg = ~br; base_addr = 32'hDEAD_BEEF; reg_list = 16'hFFFF;
    endtask

    task automatic wait_done(output int latency);
        for (int i = 0; i < 300 && done_cnt == done_base; i++) begin
            @(posedge clk);
            #1;
        end
        latency = done_edge - t0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        load_data = '{default: 32'd0};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_rf_we", 32'(rf_write_en), 32'd0);
        check_eq("rst_pc_we", 32'(pc_write_en), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // STMIA base=0x100 {R0-R3}, writeback to R13.
        start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h000F, 0);
        check_eq("stmia_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check_eq("stmia_latency", 32'(lat), 32'd6);
        check_eq("stmia_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check_eq("stmia_nbeats", 32'(beat_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("stmia_addr%0d", i), beat_addr[i], 32'h100 + 32'(4 * i));
            check_eq($sformatf("stmia_data%0d", i), beat_data[i], 32'hA000_0000 + 32'(i));
            check_eq($sformatf("stmia_we%0d", i), 32'(beat_we[i]), 32'd1);
        end
        check_eq("stmia_nrfw", 32'(rfw_num.size()), 32'd1);
        check_eq("stmia_wb_reg", 32'(rfw_num[0]), 32'd13);
        check_eq("stmia_wb_val", rfw_data[0], 32'h110);
        check_eq("stmia_npcw", 32'(pcw_data.size()), 32'd0);

        // LDMDB base=0x200 {R0,R1,R15}, two wait states per beat, no writeback.
        load_data[0] = 32'hA; load_data[1] = 32'hB; load_data[2] = 32'hC;
        start_xfer(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h200, 16'h8003, 2);
        wait_done(lat);
        check_eq("ldmdb_latency", 32'(lat), 32'd10);
        check_eq("ldmdb_nbeats", 32'(beat_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ldmdb_addr%0d", i), beat_addr[i], 32'h1F4 + 32'(4 * i));
            check_eq($sformatf("ldmdb_we%0d", i), 32'(beat_we[i]), 32'd0);
        end
        check_eq("ldmdb_nrfw", 32'(rfw_num.size()), 32'd2);
        check_eq("ldmdb_rfw0_reg", 32'(rfw_num[0]), 32'd0);
        check_eq("ldmdb_rfw0_val", rfw_data[0], 32'hA);
        check_eq("ldmdb_rfw1_reg", 32'(rfw_num[1]), 32'd1);
        check_eq("ldmdb_rfw1_val", rfw_data[1], 32'hB);
        check_eq("ldmdb_npcw", 32'(pcw_data.size()), 32'd1);
        check_eq("ldmdb_pc_val", pcw_data[0], 32'hC);

        // Empty list: straight to done, no beats, no writeback even with W set.
        start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h100, 16'h0000, 0);
        wait_done(lat);
        check_eq("empty_latency", 32'(lat), 32'd1);
        check_eq("empty_req_cycles", 32'(req_cnt - req_base), 32'd0);
        check_eq("empty_nrfw", 32'(rfw_num.size()), 32'd0);
        check_eq("empty_npcw", 32'(pcw_data.size()), 32'd0);

        // LDMIA with the base register in the list: loaded value wins, no writeback.
        load_data[0] = 32'h11; load_data[1] = 32'h22;
        start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0006, 0);
        wait_done(lat);
        check_eq("ldmia_latency", 32'(lat), 32'd3);
        check_eq("ldmia_addr0", beat_addr[0], 32'h300);
        check_eq("ldmia_addr1", beat_addr[1], 32'h304);
        check_eq("ldmia_nrfw", 32'(rfw_num.size()), 32'd2);
        check_eq("ldmia_rfw0", {rfw_data[0][27:0], rfw_num[0]}, 32'h0000_0111);
        check_eq("ldmia_rfw1", {rfw_data[1][27:0], rfw_num[1]}, 32'h0000_0222);

        // STMIB across the top of the address space; R0/R1 hold 0xA/0x11 from earlier loads.
        start_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 32'hFFFF_FFFC, 16'h0003, 0);
        wait_done(lat);
        check_eq("wrap_latency", 32'(lat), 32'd4);
        check_eq("wrap_addr0", beat_addr[0], 32'h0);
        check_eq("wrap_addr1", beat_addr[1], 32'h4);
        check_eq("wrap_data0", beat_data[0], 32'hA);
        check_eq("wrap_data1", beat_data[1], 32'h11);
        check_eq("wrap_nrfw", 32'(rfw_num.size()), 32'd1);
        check_eq("wrap_wb_reg", 32'(rfw_num[0]), 32'd4);
        check_eq("wrap_wb_val", rfw_data[0], 32'h4);

        // Reset while beat 2 of 4 is waiting for its ack.
        start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h400, 16'h000F, 3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_nbeats", 32'(beat_addr.size()), 32'd1);
        check_eq("midrst_addr0", beat_addr[0], 32'h400);
        check_eq("midrst_nrfw", 32'(rfw_num.size()), 32'd0);
        check_eq("midrst_done_cnt", 32'(done_cnt - done_base), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Normal transfer after the reset; register file model was reinitialised.
        start_xfer(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h500, 16'h0030, 0);
        wait_done(lat);
        check_eq("post_latency", 32'(lat), 32'd3);
        check_eq("post_nbeats", 32'(beat_addr.size()), 32'd2);
        check_eq("post_addr0", beat_addr[0], 32'h500);
        check_eq("post_addr1", beat_addr[1], 32'h504);
        check_eq("post_data0", beat_data[0], 32'hA000_0004);
        check_eq("post_data1", beat_data[1], 32'hA000_0005);
        check_eq("post_nrfw", 32'(rfw_num.size()), 32'd0);

        check_eq("wr_exclusive", 32'(excl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
